// File: rtl/spio_deb.sv
// spio_deb: Wishbone LED/button peripheral. It provides masked LED writes with
// per-LED blink, and synchronised, debounced buttons with press latches and a maskable interrupt.
module spio_deb #(
  parameter int unsigned NLED       = 2,
  parameter int unsigned NBTN       = 2,
  parameter int unsigned LGDEBOUNCE = 16,
  parameter int unsigned LGBLINK    = 24
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [1:0]      i_wb_addr,
  input  logic [31:0]     i_wb_data,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [31:0]     o_wb_data,
  input  logic [NBTN-1:0] i_btn,
  output logic [NLED-1:0] o_led,
  output logic            o_int
);

  localparam logic [LGDEBOUNCE-1:0] DB_ONE = {{(LGDEBOUNCE-1){1'b0}}, 1'b1};
  localparam logic [LGBLINK-1:0]    BL_ONE = {{(LGBLINK-1){1'b0}}, 1'b1};

  logic                  w_stb, w_wr, w_unused;
  logic [NLED-1:0]       r_led, r_blink, r_oled;
  logic [NBTN-1:0]       r_ien, r_latch, r_stable, r_stable_d, r_sync1, r_sync2;
  logic [NBTN-1:0]       w_clr, w_rise;
  logic [LGDEBOUNCE-1:0] r_cnt [NBTN];
  logic [LGBLINK-1:0]    r_bcnt;
  logic                  r_ack, r_int;
  logic [31:0]           r_rdata, w_rdata;
  logic [7:0]            w_led8, w_blink8, w_ien8, w_stable8, w_latch8;

  assign w_stb      = i_wb_cyc && i_wb_stb && !i_reset;
  assign w_wr       = w_stb && i_wb_we;
  assign w_clr      = (w_wr && i_wb_addr == 2'd1) ? i_wb_data[8 +: NBTN] : '0;
  assign w_rise     = r_stable & ~r_stable_d;
  assign w_unused   = ^{1'b0, i_wb_data};
  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = r_ack;
  assign o_wb_data  = r_rdata;
  assign o_led      = r_oled;
  assign o_int      = r_int;

  always_comb begin
    w_led8    = '0;
    w_blink8  = '0;
    w_ien8    = '0;
    w_stable8 = '0;
    w_latch8  = '0;
    w_led8[NLED-1:0]    = r_led;
    w_blink8[NLED-1:0]  = r_blink;
    w_ien8[NBTN-1:0]    = r_ien;
    w_stable8[NBTN-1:0] = r_stable;
    w_latch8[NBTN-1:0]  = r_latch;
    case (i_wb_addr)
      2'd0:    w_rdata = {24'h0, w_led8};
      2'd1:    w_rdata = {16'h0, w_latch8, w_stable8};
      2'd2:    w_rdata = {24'h0, w_ien8};
      default: w_rdata = {24'h0, w_blink8};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_led   <= '0;
      r_ien   <= '0;
      r_blink <= '0;
    end else begin
      r_ack <= w_stb;
      if (w_stb)
        r_rdata <= w_rdata;
      if (w_wr) begin
        case (i_wb_addr)
          2'd0:
            for (int unsigned k = 0; k < NLED; k++)
              if (i_wb_data[k+8])
                r_led[k] <= i_wb_data[k];
          2'd2:    r_ien   <= i_wb_data[NBTN-1:0];
          2'd3:    r_blink <= i_wb_data[NLED-1:0];
          default: ;
        endcase
      end
    end
  end

  // Any cycle of agreement restarts the window; a flip needs a full run of disagreement.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_latch    <= '0;
      for (int unsigned k = 0; k < NBTN; k++)
        r_cnt[k] <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_latch    <= (r_latch & ~w_clr) | w_rise;
      for (int unsigned k = 0; k < NBTN; k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == '1) begin
          r_stable[k] <= r_sync2[k];
          r_cnt[k]    <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + DB_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bcnt <= '0;
      r_oled <= '0;
      r_int  <= 1'b0;
    end else begin
      r_bcnt <= r_bcnt + BL_ONE;
      r_oled <= r_led & (~r_blink | {NLED{r_bcnt[LGBLINK-1]}});
      r_int  <= |(r_latch & r_ien);
    end
  end

endmodule

// File: tb/tb_spio_deb.sv
// Bench for spio_deb: directed scenarios, a register vector table, and random traffic.
// A cycle-level reference model checks every output on every cycle.
module tb_spio_deb;
  localparam int NLED = 4;
  localparam int NBTN = 3;
  localparam int LGD  = 4;
  localparam int LGB  = 4;
  localparam int WIN  = 1 << LGD;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            cyc   = 1'b0;
  logic            stb   = 1'b0;
  logic            we    = 1'b0;
  logic [1:0]      addr  = '0;
  logic [31:0]     wdata = '0;
  logic [NBTN-1:0] btn   = '1;
  logic            stall, ack, intr;
  logic [31:0]     rdata;
  logic [NLED-1:0] led;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spio_deb #(.NLED(NLED), .NBTN(NBTN), .LGDEBOUNCE(LGD), .LGBLINK(LGB)) dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_stall(stall), .o_wb_ack(ack),
    .o_wb_data(rdata), .i_btn(btn), .o_led(led), .o_int(intr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NLED-1:0] m_led = '0, m_blink = '0, m_oled = '0;
  logic [NBTN-1:0] m_ien = '0, m_latch = '0, m_stable = '0, m_stable_d = '0;
  logic            m_ack = 1'b0, m_int = 1'b0;
  logic [31:0]     m_rdata = '0;
  int              m_ncnt = 0;
  logic [NBTN-1:0] hist[$];

  function automatic logic [31:0] regread(input logic [1:0] a);
    logic [31:0] r = '0;
    case (a)
      2'd0: r[NLED-1:0] = m_led;
      2'd1: begin r[NBTN-1:0] = m_stable; r[8 +: NBTN] = m_latch; end
      2'd2: r[NBTN-1:0] = m_ien;
      default: r[NLED-1:0] = m_blink;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic            s, all_diff, phase;
    logic [NBTN-1:0] rise, clr, n_stable;
    s = cyc & stb & ~rst;
    if (rst) begin
      m_led = '0; m_blink = '0; m_oled = '0; m_ien = '0; m_latch = '0;
      m_stable = '0; m_stable_d = '0; m_ack = 1'b0; m_int = 1'b0;
      m_rdata = '0; m_ncnt = 0;
      hist.delete();
      for (int i = 0; i < WIN + 2; i++) hist.push_back('0);
    end else begin
      phase  = (m_ncnt % (1 << LGB)) >= (1 << (LGB - 1));
      m_oled = m_led & (~m_blink | (phase ? '1 : '0));
      m_int  = |(m_latch & m_ien);
      rise   = m_stable & ~m_stable_d;
      clr    = (s && we && addr == 2'd1) ? wdata[8 +: NBTN] : '0;
      // Button flips once its synchronised input has disagreed for WIN consecutive samples.
      hist.push_back(btn);
      while (hist.size() > WIN + 2) void'(hist.pop_front());
      n_stable = m_stable;
      for (int k = 0; k < NBTN; k++) begin
        all_diff = 1'b1;
        for (int i = 0; i < WIN; i++)
          if (hist[i][k] == m_stable[k]) all_diff = 1'b0;
        if (all_diff) n_stable[k] = ~m_stable[k];
      end
      if (s) begin
        m_rdata = regread(addr);
        if (we) begin
          case (addr)
            2'd0: for (int k = 0; k < NLED; k++) if (wdata[k+8]) m_led[k] = wdata[k];
            2'd2: m_ien = wdata[NBTN-1:0];
            2'd3: m_blink = wdata[NLED-1:0];
            default: ;
          endcase
        end
      end
      m_ack      = s;
      m_latch    = (m_latch & ~clr) | rise;
      m_stable_d = m_stable;
      m_stable   = n_stable;
      m_ncnt++;
    end
  end

  always @(negedge clk) begin
    chk("m_ack",   {31'b0, ack},   {31'b0, m_ack});
    chk("m_rdata", rdata,          m_rdata);
    chk("m_led",   {28'b0, led},   {28'b0, m_oled});
    chk("m_int",   {31'b0, intr},  {31'b0, m_int});
    chk("stall",   {31'b0, stall}, 32'h0);
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int trans, bad;
    logic p;

    vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0A};
    vecs[1]  = '{1'b1, 2'd0, 32'h0105,     32'h0};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,        32'h0B};
    vecs[3]  = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'h0};
    vecs[4]  = '{1'b0, 2'd2, 32'h0,        32'h07};
    vecs[5]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0};
    vecs[6]  = '{1'b0, 2'd3, 32'h0,        32'h0F};
    vecs[7]  = '{1'b1, 2'd3, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 2'd2, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 2'd2, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 2'd1, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 2'd0, 32'h0F00,     32'h0};
    vecs[13] = '{1'b0, 2'd0, 32'h0,        32'h0};

    // 1: reset with buttons high
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_outs", {27'b0, ack, intr, led}, 32'h0);
      chk("rst_data", rdata, 32'h0);
    end
    rst = 1'b0;
    bus(1'b0, 2'd1, 32'h0);
    chk("btn_after_rst", rdata, 32'h0);
    btn = '0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // 2: masked LED write and latency
    bus(1'b1, 2'd0, 32'h0F0A);
    chk("led_wr_ack", {31'b0, ack}, 32'h1);
    chk("led_wr_t1", {28'b0, led}, 32'h0);
    @(posedge clk); #1;
    chk("led_wr_t2", {28'b0, led}, 32'hA);
    for (int i = 0; i < 14; i++) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].data);
      chk("tbl_ack", {31'b0, ack}, 32'h1);
      if (!vecs[i].we) chk("tbl_rd", rdata, vecs[i].exp);
    end

    // 3: glitch rejection then press timing
    btn[1] = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn[1] = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    bus(1'b0, 2'd1, 32'h0);
    chk("glitch_rej", rdata, 32'h0);
    btn[1] = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (j == 17) chk("stable_e17", rdata, 32'h0);
      if (j == 18) chk("stable_e18", rdata, 32'h0002);
      if (j == 19) chk("latch_e19", rdata, 32'h0202);
    end
    cyc = 1'b0; stb = 1'b0;

    // 4: interrupt enable, clear, and set-wins-over-clear
    bus(1'b1, 2'd2, 32'h2);
    chk("int_ien_t1", {31'b0, intr}, 32'h0);
    @(posedge clk); #1;
    chk("int_ien_t2", {31'b0, intr}, 32'h1);
    bus(1'b1, 2'd1, 32'h0200);
    chk("int_clr_t1", {31'b0, intr}, 32'h1);
    @(posedge clk); #1;
    chk("int_clr_t2", {31'b0, intr}, 32'h0);
    bus(1'b0, 2'd1, 32'h0);
    chk("btn_cleared", rdata, 32'h0002);
    btn[1] = 1'b0;
    repeat (25) @(posedge clk);
    #1 btn[1] = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    bus(1'b1, 2'd1, 32'h0200);
    bus(1'b0, 2'd1, 32'h0);
    chk("set_wins", rdata, 32'h0202);
    chk("set_wins_int", {31'b0, intr}, 32'h1);
    bus(1'b1, 2'd1, 32'h0200);
    bus(1'b1, 2'd2, 32'h0);

    // 5: blink
    bus(1'b1, 2'd0, 32'h0F0F);
    bus(1'b1, 2'd3, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    trans = 0; bad = 0; p = led[2];
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (led[2] !== p) trans++;
      p = led[2];
      if ({led[3], led[1:0]} !== 3'b111) bad++;
    end
    chk("blink_toggles", trans, 32'd4);
    chk("blink_others", bad, 32'd0);
    bus(1'b1, 2'd3, 32'h0);
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (led !== 4'hF) bad++;
    end
    chk("blink_off", bad, 32'd0);

    // 6: back-to-back write then read
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd3; wdata = 32'hA;
    @(posedge clk); #1;
    chk("b2b_ack1", {31'b0, ack}, 32'h1);
    we = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ack2", {31'b0, ack}, 32'h1);
    chk("b2b_rd", rdata, 32'hA);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ack_end", {31'b0, ack}, 32'h0);

    // random traffic against the model
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) btn[$urandom_range(0, NBTN-1)] ^= 1'b1;
      cyc   = ($urandom_range(0, 3) != 0);
      stb   = ($urandom_range(0, 2) == 0);
      we    = $urandom_range(0, 1) == 1;
      addr  = 2'($urandom_range(0, 3));
      wdata = $urandom();
      rst   = ($urandom_range(0, 599) == 0);
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
